// File: rtl/nes_oam_dma_pkg.sv
// Shared definitions for the sprite-DMA controller: state encoding, default
// trigger/target addresses and a bus-ownership helper.
package nes_oam_dma_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_WAIT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] DMA_TARGET_ADDR  = 16'h2004;

  function automatic logic dma_owns_bus(input dma_state_e s);
    return (s == DMA_ALIGN) || (s == DMA_READ) || (s == DMA_WRITE);
  endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// Sprite-DMA controller and bus arbiter: a CPU write to the trigger address
// halts the CPU and copies one 256-byte page to the OAM data port.
module nes_oam_dma
  import nes_oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = DMA_TRIGGER_ADDR,
  parameter logic [15:0] TARGET_ADDR  = DMA_TARGET_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_d_in,
  output logic [15:0] bus_a,
  output logic        bus_rw,
  output logic [7:0]  bus_d_out,
  output logic        cpu_rdy,
  output logic        dma_active
);

  dma_state_e  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  data_reg_q, data_reg_d;
  logic        parity_q, parity_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DMA_IDLE;
      page_q     <= 8'h00;
      byte_idx_q <= 8'h00;
      data_reg_q <= 8'h00;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      byte_idx_q <= byte_idx_d;
      data_reg_q <= data_reg_d;
      parity_q   <= parity_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    byte_idx_d = byte_idx_q;
    data_reg_d = data_reg_q;
    parity_d   = ~parity_q;
    unique case (state_q)
      DMA_IDLE: begin
        if (cpu_rw && (cpu_a == TRIGGER_ADDR)) begin
          page_d     = cpu_d_out;
          byte_idx_d = 8'h00;
          state_d    = DMA_WAIT;
        end
      end
      DMA_WAIT: begin
        // The next cycle's parity is ~parity_q; READ must land on parity 0.
        if (!cpu_rw) state_d = parity_q ? DMA_READ : DMA_ALIGN;
      end
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ: begin
        data_reg_d = bus_d_in;
        state_d    = DMA_WRITE;
      end
      DMA_WRITE: begin
        byte_idx_d = byte_idx_q + 8'd1;
        state_d    = (byte_idx_q == 8'hFF) ? DMA_IDLE : DMA_READ;
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  always_comb begin
    bus_a      = cpu_a;
    bus_rw     = cpu_rw;
    bus_d_out  = cpu_d_out;
    cpu_rdy    = (state_q == DMA_IDLE);
    dma_active = dma_owns_bus(state_q);
    unique case (state_q)
      DMA_ALIGN: begin
        bus_a     = {page_q, 8'h00};
        bus_rw    = 1'b0;
        bus_d_out = 8'h00;
      end
      DMA_READ: begin
        bus_a     = {page_q, byte_idx_q};
        bus_rw    = 1'b0;
        bus_d_out = 8'h00;
      end
      DMA_WRITE: begin
        bus_a     = TARGET_ADDR;
        bus_rw    = 1'b1;
        bus_d_out = data_reg_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Self-checking bench for nes_oam_dma: passthrough vector table, directed
// transfer scenarios and randomized transfers against a page-copy model.
module tb_nes_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d_out;
  logic        cpu_rw;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_a;
  logic        bus_rw;
  logic [7:0]  bus_d_out;
  logic        cpu_rdy;
  logic        dma_active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] wq [$];

  always #5 clk = ~clk;

  nes_oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_a      (cpu_a),
    .cpu_d_out  (cpu_d_out),
    .cpu_rw     (cpu_rw),
    .bus_d_in   (bus_d_in),
    .bus_a      (bus_a),
    .bus_rw     (bus_rw),
    .bus_d_out  (bus_d_out),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active)
  );

  assign bus_d_in = bus_rw ? 8'h00 : mem[bus_a];

  // Cycle index since reset release; its LSB is the bus parity.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
    if (bus_rw && bus_a == 16'h2004) wq.push_back(bus_d_out);
  end

  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
    logic [15:0] ea;
    logic        erw;
    logic [7:0]  ed;
    logic        erdy;
    logic        eact;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    cpu_a = a; cpu_rw = rw; cpu_d_out = d;
    #1;
  endtask

  // One full transfer: optional phase control of the trigger cycle, ww CPU
  // writes held in WAIT, optional CPU noise (incl. retriggers) while halted.
  task automatic run_xfer(input string tag, input logic [7:0] page, input int ww,
                          input int want_par, input bit noise,
                          output int stall, output int aligned);
    int t_par, exp_len, errs, derr, k, j;
    bit done;
    logic [15:0] ea, na;
    logic        erw;
    logic [7:0]  ed, ib;
    if (want_par >= 0 && (((cyc + 1) & 1) != want_par))
      step(16'h0123, 1'b0, 8'h00);
    wq.delete();
    step(16'h4014, 1'b1, page);
    t_par = cyc & 1;
    check({tag, "_trig"}, {bus_a, bus_rw, bus_d_out, cpu_rdy, dma_active},
          {16'h4014, 1'b1, page, 1'b1, 1'b0});
    stall = 0; errs = 0;
    for (int i = 0; i < ww; i++) begin
      na = (i == 0) ? 16'h4014 : 16'($urandom_range(0, 16'h1FFF));
      ed = 8'($urandom);
      step(na, 1'b1, ed);
      if (!cpu_rdy) stall++;
      if ({bus_a, bus_rw, bus_d_out, cpu_rdy, dma_active} !== {na, 1'b1, ed, 1'b0, 1'b0}) errs++;
    end
    na = 16'($urandom);
    step(na, 1'b0, 8'h00);
    if (!cpu_rdy) stall++;
    if ({bus_a, bus_rw, cpu_rdy, dma_active} !== {na, 1'b0, 1'b0, 1'b0}) errs++;
    check({tag, "_wait"}, errs, 0);
    aligned = (t_par + ww + 2) & 1;
    exp_len = aligned + 512;
    errs = 0; done = 0;
    for (k = 0; k < 600 && !done; k++) begin
      if (noise && k < exp_len - 1) begin
        case ($urandom_range(0, 2))
          0: step(16'h4014, 1'b1, 8'h07);
          1: step(16'($urandom_range(0, 16'h1FFF)), 1'b1, 8'($urandom));
          default: step(16'($urandom), 1'b0, 8'h00);
        endcase
      end else begin
        step(16'($urandom), 1'b0, 8'h00);
      end
      if (cpu_rdy) begin
        done = 1;
      end else begin
        stall++;
        if (k < exp_len) begin
          if (aligned && k == 0) begin
            ea = {page, 8'h00}; erw = 1'b0; ed = 8'h00;
          end else begin
            j  = k - aligned;
            ib = 8'(j >> 1);
            if ((j & 1) == 0) begin
              ea = {page, ib}; erw = 1'b0; ed = 8'h00;
              if ((cyc & 1) != 0) errs++;
            end else begin
              ea = 16'h2004; erw = 1'b1; ed = mem[{page, ib}];
            end
          end
          if ({bus_a, bus_rw, bus_d_out, dma_active} !== {ea, erw, ed, 1'b1}) errs++;
        end
      end
    end
    check({tag, "_timeout"}, done, 1);
    check({tag, "_cycles"}, errs, 0);
    check({tag, "_stall"}, stall, ww + 1 + exp_len);
    check({tag, "_resume"}, {bus_a, bus_rw, dma_active}, {cpu_a, cpu_rw, 1'b0});
    check({tag, "_wcount"}, wq.size(), 256);
    derr = 0;
    for (int i = 0; i < 256; i++)
      if (i >= wq.size() || wq[i] !== mem[{page, 8'(i)}]) derr++;
    check({tag, "_wdata"}, derr, 0);
  endtask

  vec_t vecs [6];
  int   st, al, n, wcnt;
  bit   hit;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    rst = 1'b1; cpu_a = 16'h0000; cpu_rw = 1'b0; cpu_d_out = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset", {bus_a, bus_rw, bus_d_out, cpu_rdy, dma_active},
          {16'h0000, 1'b0, 8'h00, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // Non-trigger accesses in IDLE pass straight through
    vecs[0] = '{16'h8000, 1'b0, 8'h00, 16'h8000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{16'h4015, 1'b1, 8'h3C, 16'h4015, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{16'h2004, 1'b1, 8'h99, 16'h2004, 1'b1, 8'h99, 1'b1, 1'b0};
    vecs[3] = '{16'h4014, 1'b0, 8'h02, 16'h4014, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{16'h4013, 1'b1, 8'hA1, 16'h4013, 1'b1, 8'hA1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFC, 1'b0, 8'h00, 16'hFFFC, 1'b0, 8'h00, 1'b1, 1'b0};
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].rw, vecs[i].d);
      check($sformatf("vec%0d", i), {bus_a, bus_rw, bus_d_out, cpu_rdy, dma_active},
            {vecs[i].ea, vecs[i].erw, vecs[i].ed, vecs[i].erdy, vecs[i].eact});
    end

    run_xfer("basic", 8'h02, 0, -1, 1'b0, st, al);
    check("basic_first", wq.size() > 0 ? wq[0] : 8'hxx, 8'h5A);
    check("basic_last", wq.size() > 255 ? wq[255] : 8'hxx, 8'hA5);

    run_xfer("align1", 8'h02, 0, 1, 1'b0, st, al);
    check("align1_len", {al[0], 16'(st)}, {1'b1, 16'd514});
    run_xfer("align0", 8'h02, 0, 0, 1'b0, st, al);
    check("align0_len", {al[0], 16'(st)}, {1'b0, 16'd513});

    run_xfer("waitwr", 8'h02, 2, -1, 1'b0, st, al);
    run_xfer("retrig", 8'h02, 0, -1, 1'b1, st, al);

    // Reset after the 100th DMA write abandons the transfer
    wq.delete();
    step(16'h4014, 1'b1, 8'h02);
    wcnt = 0; hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      step(16'h0010, 1'b0, 8'h00);
      if (bus_rw && bus_a == 16'h2004) wcnt++;
      if (wcnt == 100) hit = 1;
    end
    check("rst_reach100", hit, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_a = 16'h1234; cpu_rw = 1'b0;
    #1;
    check("rst_mid", {cpu_rdy, dma_active, bus_a, bus_rw}, {1'b1, 1'b0, 16'h1234, 1'b0});
    n = wq.size();
    check("rst_wcount", n, 100);
    repeat (600) step(16'($urandom), 1'b0, 8'h00);
    check("rst_nowrites", wq.size(), n);
    run_xfer("rst_fresh", 8'h02, 0, -1, 1'b0, st, al);

    for (int r = 0; r < 6; r++)
      run_xfer($sformatf("rnd%0d", r), 8'($urandom), $urandom_range(0, 2),
               $urandom_range(0, 1), 1'b1, st, al);
    run_xfer("page40", 8'h40, 1, -1, 1'b1, st, al);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
